la_iopocseq: RTL
================

LA_IOPOCSEQ -- requirements
Module: la_iopocseq

Interface
REQ-001 SHALL have parameter PROP, default "DEFAULT": cell property string, passed through with no functional effect.
REQ-002 SHALL have parameter RINGW, default 8: ioring width; legal values are 4 or more.
REQ-003 SHALL have parameter DLYW, default 8: width of the step-delay value.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port en, input, 1 bit: level request to power the IO ring on; synchronous to clk.
REQ-007 SHALL have port vddio_ok, input, 1 bit: IO supply good; asynchronous to clk.
REQ-008 SHALL have port dly, input, DLYW bits: per-step settle time, in cycles minus one.
REQ-009 SHALL have port ioring, output, RINGW bits: control word for the power-on control cell.
- Bit 0 = poc (IO held safe).
- Bit 1 = iso (core isolation).
- Bit 2 = oe (global output enable).
- Bit 3 = ie (global input enable).
- Bits RINGW-1:4 are always 0.
REQ-010 SHALL have port ready, output, 1 bit: high only in state ON.
REQ-011 SHALL have port state, output, 3 bits: current state encoding.
REQ-012 SHALL have port fault, output, 1 bit: sticky supply-loss flag.

Function
REQ-013 SHALL synchronise vddio_ok through two flops, reset to 0; the result is called vs below.
REQ-014 SHALL implement these states, with encoding and ioring[3:0] value (ie,oe,iso,poc):
- OFF = 0, 0011
- UP1 = 1, 0011
- UP2 = 2, 0010
- UP3 = 3, 0000
- ON = 4, 1100
- DN1 = 5, 0000
- DN2 = 6, 0010
REQ-015 SHALL drive ioring, ready and state from flops that update on the same edge as the state register, with no combinational decode on the outputs.
REQ-016 SHALL, in OFF, move to UP1 on the first edge where en=1 and vs=1 and fault=0.
REQ-017 SHALL, on entry to each of UP1, UP2, UP3, DN1 and DN2, capture dly and clear a step counter; the state then lasts exactly dly+1 cycles (dly=0 gives 1 cycle).
REQ-018 SHALL step through the sequence UP1→UP2→UP3→ON and ON→DN1→DN2→OFF when each step counter expires.
REQ-019 SHALL, in ON, move to DN1 on the first edge where en=0.
REQ-020 SHALL handle en=0 during power-up as follows:
- In UP1: go to OFF on the next edge.
- In UP2 or UP3: go to DN2 on the next edge.
REQ-021 SHALL ignore en=1 during DN1 and DN2; the power-down completes to OFF, and REQ-016 then restarts power-up.
REQ-022 SHALL, when vs=0 in any state other than OFF, go to OFF on the next edge and set fault=1; this takes priority over all other transitions.
REQ-023 SHALL clear fault on the edge where it samples en=0 while in OFF; while fault=1, OFF is held.
REQ-024 SHALL saturate the step counter at dly, so that no wrap-around occurs.
REQ-025 SHALL keep all state paths free of lockup; unused encoding 7 SHALL go to OFF on the next edge.

Reset
REQ-026 SHALL, while reset=1 asynchronously, force the outputs to:
- state=OFF
- ioring=all-zero except poc=1 and iso=1
- ready=0
- fault=0
- step counter=0
- synchroniser flops=0
REQ-027 SHALL, on reset asserted mid-sequence (including in ON), reach the reset values immediately, without passing through DN1 or DN2.
REQ-028 SHALL, after reset release, need at least 2 cycles for vs to rise before leaving OFF.

Verification
REQ-029 SHALL cover power-up: dly=2, vddio_ok=1 for ≥3 cycles, en raised → UP1 on the next edge, ioring[3:0] = 0011 for 3 cycles, 0010 for 3, 0000 for 3, then 1100 with ready=1.
REQ-030 SHALL cover power-down: in ON with dly=1, en dropped → ioring[3:0] = 0000 for 2 cycles, then 0010 for 2 cycles, then OFF with 0011 and ready=0.
REQ-031 SHALL cover supply loss: vddio_ok dropped in ON → 2 cycles of sync latency, then OFF with ioring 0011 and fault=1; re-raising en with vddio_ok=1 gives no power-up until en has been 0 for at least one cycle.
REQ-032 SHALL cover abort: dly=5, en dropped in the 2nd cycle of UP2 → DN2 (0010) for 6 cycles, then OFF.
REQ-033 SHALL cover asynchronous reset: reset pulsed in UP3 between clock edges → ioring 0011, state 0 and ready 0 immediately, before the next clk edge.
REQ-034 SHALL cover the zero-delay boundary: dly=0 → each intermediate state lasts exactly 1 cycle, and ON is reached 3 cycles after UP1 is entered.

Source files
------------

// File: rtl/la_iopocseq.sv
// IO ring power-on control sequencer: walks the POC cell through
// safe/isolated/enabled phases with per-step settle times and supply-loss guard.
module la_iopocseq #(
    parameter string PROP  = "DEFAULT",
    parameter int    RINGW = 8,
    parameter int    DLYW  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             vddio_ok,
    input  logic [DLYW-1:0]  dly,
    output logic [RINGW-1:0] ioring,
    output logic             ready,
    output logic [2:0]       state,
    output logic             fault
);

    typedef enum logic [2:0] {
        S_OFF = 3'd0,
        S_UP1 = 3'd1,
        S_UP2 = 3'd2,
        S_UP3 = 3'd3,
        S_ON  = 3'd4,
        S_DN1 = 3'd5,
        S_DN2 = 3'd6
    } state_t;

    localparam logic [RINGW-1:0] IO_RST = RINGW'(4'b0011);

    logic             s1_q, s2_q;
    logic             vs;
    state_t           state_q, state_d;
    logic [DLYW-1:0]  cnt_q, cnt_d;
    logic [DLYW-1:0]  lim_q, lim_d;
    logic             fault_q, fault_d;
    logic [RINGW-1:0] ioring_q, ioring_d;
    logic             ready_q, ready_d;
    logic             expired;
    logic [3:0]       io4;

    assign vs      = s2_q;
    assign expired = (cnt_q == lim_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= vddio_ok;
            s2_q <= s1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        if (state_q != S_OFF && !vs) begin
            state_d = S_OFF;
            fault_d = 1'b1;
        end else begin
            unique case (state_q)
                S_OFF: begin
                    if (fault_q) begin
                        if (!en) fault_d = 1'b0;
                    end else if (en && vs) begin
                        state_d = S_UP1;
                    end
                end
                S_UP1: begin
                    if (!en)          state_d = S_OFF;
                    else if (expired) state_d = S_UP2;
                end
                S_UP2: begin
                    if (!en)          state_d = S_DN2;
                    else if (expired) state_d = S_UP3;
                end
                S_UP3: begin
                    if (!en)          state_d = S_DN2;
                    else if (expired) state_d = S_ON;
                end
                S_ON:  if (!en)    state_d = S_DN1;
                S_DN1: if (expired) state_d = S_DN2;
                S_DN2: if (expired) state_d = S_OFF;
                default: state_d = S_OFF;
            endcase
        end
    end

    // Every state change reloads the step limit and restarts the count.
    always_comb begin
        cnt_d = cnt_q;
        lim_d = lim_q;
        if (state_d != state_q) begin
            cnt_d = '0;
            lim_d = dly;
        end else if (!expired) begin
            cnt_d = cnt_q + DLYW'(1);
        end
    end

    always_comb begin
        io4 = 4'b0000;
        unique case (state_d)
            S_OFF, S_UP1: io4 = 4'b0011;
            S_UP2, S_DN2: io4 = 4'b0010;
            S_ON:         io4 = 4'b1100;
            default:      io4 = 4'b0000;
        endcase
        ioring_d = RINGW'(io4);
        ready_d  = (state_d == S_ON);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_OFF;
            cnt_q    <= '0;
            lim_q    <= '0;
            fault_q  <= 1'b0;
            ioring_q <= IO_RST;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lim_q    <= lim_d;
            fault_q  <= fault_d;
            ioring_q <= ioring_d;
            ready_q  <= ready_d;
        end
    end

    assign ioring = ioring_q;
    assign ready  = ready_q;
    assign state  = state_q;
    assign fault  = fault_q;

endmodule
